rr_hold_arbiter: RTL and testbench

- Round-robin arbiter with grant hold, for sharing a single resource among N requesters.
- Successor to the fixed-priority grant logic: rotating priority gives fairness, and a bounded hold time prevents starvation.
- A grant is held until the grantee signals completion, drops its request, or hits the hold limit.
- Sits between the requesting engines and the shared resource mux. `gnt` and `gnt_id` drive the mux select directly.

---
 rtl/rr_hold_arbiter_if.sv | 24 ++
 rtl/rr_hold_arbiter.sv | 108 ++++++++++
 tb/tb_rr_hold_arbiter.sv | 132 +++++++++++++
 3 files changed

// File: rtl/rr_hold_arbiter_if.sv
// Request/grant bundle between the requesting engines and the round-robin arbiter.
// The arbiter takes the slave view; the engines (or a bench) take the master view.
interface rr_hold_arbiter_if #(
    parameter int N    = 4,
    parameter int ID_W = $clog2(N)
);
    logic [N-1:0]    req;
    logic            done;
    logic [N-1:0]    gnt;
    logic            gnt_valid;
    logic [ID_W-1:0] gnt_id;
    logic            timeout;
    logic [ID_W-1:0] ptr;

    modport master (
        output req, done,
        input  gnt, gnt_valid, gnt_id, timeout, ptr
    );

    modport slave (
        input  req, done,
        output gnt, gnt_valid, gnt_id, timeout, ptr
    );
endinterface

// File: rtl/rr_hold_arbiter.sv
// Round-robin arbiter with bounded grant hold for a single shared resource.
// Every grant is followed by at least one idle cycle before the next one is issued.
module rr_hold_arbiter #(
    parameter int N        = 4,
    parameter int MAX_HOLD = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    rr_hold_arbiter_if.slave bus
);
    localparam int ID_W  = $clog2(N);
    localparam int CNT_W = 8;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t           state_q, state_d;
    logic [N-1:0]     gnt_q, gnt_d;
    logic             gnt_valid_q, gnt_valid_d;
    logic [ID_W-1:0]  gnt_id_q, gnt_id_d;
    logic [ID_W-1:0]  ptr_q, ptr_d;
    logic             timeout_q, timeout_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [ID_W-1:0]  sel;
    logic             found;
    logic             owner_req;
    logic             at_limit;
    logic             release_grant;

    // First set request at or after ptr, wrapping past N-1 back to 0.
    always_comb begin
        found = 1'b0;
        sel   = '0;
        for (int i = 0; i < N; i++) begin
            if (!found && bus.req[(int'(ptr_q) + i) % N]) begin
                found = 1'b1;
                sel   = ID_W'((int'(ptr_q) + i) % N);
            end
        end
    end

    assign owner_req     = bus.req[gnt_id_q];
    assign at_limit      = (cnt_q == CNT_W'(MAX_HOLD - 1));
    assign release_grant = bus.done | ~owner_req | at_limit;

    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        gnt_valid_d = gnt_valid_q;
        gnt_id_d    = gnt_id_q;
        ptr_d       = ptr_q;
        cnt_d       = cnt_q;
        timeout_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (found) begin
                    state_d     = BUSY;
                    gnt_d       = '0;
                    gnt_d[sel]  = 1'b1;
                    gnt_valid_d = 1'b1;
                    gnt_id_d    = sel;
                    ptr_d       = (sel == ID_W'(N - 1)) ? '0 : sel + 1'b1;
                    cnt_d       = '0;
                end
            end
            BUSY: begin
                if (release_grant) begin
                    state_d     = IDLE;
                    gnt_d       = '0;
                    gnt_valid_d = 1'b0;
                    gnt_id_d    = '0;
                    cnt_d       = '0;
                    // Flag only releases forced purely by the hold limit.
                    timeout_d   = at_limit & ~bus.done & owner_req;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            gnt_q       <= '0;
            gnt_valid_q <= 1'b0;
            gnt_id_q    <= '0;
            ptr_q       <= '0;
            timeout_q   <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            gnt_valid_q <= gnt_valid_d;
            gnt_id_q    <= gnt_id_d;
            ptr_q       <= ptr_d;
            timeout_q   <= timeout_d;
            cnt_q       <= cnt_d;
        end
    end

    assign bus.gnt       = gnt_q;
    assign bus.gnt_valid = gnt_valid_q;
    assign bus.gnt_id    = gnt_id_q;
    assign bus.timeout   = timeout_q;
    assign bus.ptr       = ptr_q;
endmodule

// File: tb/tb_rr_hold_arbiter.sv
// Directed bench for rr_hold_arbiter (N=4, MAX_HOLD=8) with hand-computed expectations.
module tb_rr_hold_arbiter;
    logic clk = 1'b0;
    logic reset_n;
    int   total = 0;
    int   bad   = 0;

    rr_hold_arbiter_if #(.N(4)) bus ();

    rr_hold_arbiter #(
        .N        (4),
        .MAX_HOLD (8)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic expect_out(input string tag, input logic [3:0] g, input logic [1:0] id,
                              input logic tmo, input logic [1:0] p);
        chk({tag, ".gnt"},       32'(bus.gnt),       32'(g));
        chk({tag, ".gnt_valid"}, 32'(bus.gnt_valid), 32'(|g));
        chk({tag, ".gnt_id"},    32'(bus.gnt_id),    32'(id));
        chk({tag, ".timeout"},   32'(bus.timeout),   32'(tmo));
        chk({tag, ".ptr"},       32'(bus.ptr),       32'(p));
    endtask

    logic [3:0] rr_gnt [5];
    logic [1:0] rr_id  [5];
    logic [1:0] rr_ptr [5];

    initial begin
        rr_gnt = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        rr_id  = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        rr_ptr = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};

        // Reset holds everything at zero despite full request vector
        reset_n  = 1'b0;
        bus.req  = 4'b1111;
        bus.done = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            expect_out("reset", 4'b0000, 2'd0, 1'b0, 2'd0);
        end

        // Single requester, done on third grant cycle, then request drop
        reset_n = 1'b1;
        bus.req = 4'b0100;
        tick(); expect_out("single.c1", 4'b0100, 2'd2, 1'b0, 2'd3);
        tick(); expect_out("single.c2", 4'b0100, 2'd2, 1'b0, 2'd3);
        tick(); expect_out("single.c3", 4'b0100, 2'd2, 1'b0, 2'd3);
        bus.done = 1'b1;
        tick(); expect_out("single.c4", 4'b0000, 2'd0, 1'b0, 2'd3);
        bus.done = 1'b0;
        tick(); expect_out("single.c5", 4'b0100, 2'd2, 1'b0, 2'd3);
        bus.req = 4'b0000;
        tick(); expect_out("drop", 4'b0000, 2'd0, 1'b0, 2'd3);
        tick(); expect_out("idle", 4'b0000, 2'd0, 1'b0, 2'd3);

        // Rotation from ptr=0 with one-cycle grants
        reset_n = 1'b0;
        tick(); expect_out("reset2", 4'b0000, 2'd0, 1'b0, 2'd0);
        reset_n = 1'b1;
        bus.req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            tick(); expect_out("rr.grant", rr_gnt[k], rr_id[k], 1'b0, rr_ptr[k]);
            bus.done = 1'b1;
            tick(); expect_out("rr.bubble", 4'b0000, 2'd0, 1'b0, rr_ptr[k]);
            bus.done = 1'b0;
        end
        bus.req = 4'b0000;

        // Hold limit: eight grant cycles then a one-cycle timeout pulse
        tick(); expect_out("idle2", 4'b0000, 2'd0, 1'b0, 2'd1);
        bus.req = 4'b0010;
        tick(); expect_out("tmo.g1", 4'b0010, 2'd1, 1'b0, 2'd2);
        for (int i = 2; i <= 8; i++) begin
            tick(); expect_out("tmo.hold", 4'b0010, 2'd1, 1'b0, 2'd2);
        end
        tick(); expect_out("tmo.pulse", 4'b0000, 2'd0, 1'b1, 2'd2);
        tick(); expect_out("tmo.regrant", 4'b0010, 2'd1, 1'b0, 2'd2);

        // done coinciding with the last hold cycle is a normal release
        for (int i = 2; i <= 8; i++) begin
            tick(); expect_out("coinc.hold", 4'b0010, 2'd1, 1'b0, 2'd2);
            if (i == 8) bus.done = 1'b1;
        end
        tick(); expect_out("coinc.rel", 4'b0000, 2'd0, 1'b0, 2'd2);
        bus.req = 4'b0000;
        tick(); expect_out("idle.done", 4'b0000, 2'd0, 1'b0, 2'd2);
        bus.done = 1'b0;

        // Reset in the middle of a grant
        bus.req = 4'b0110;
        tick(); expect_out("mid.g1", 4'b0100, 2'd2, 1'b0, 2'd3);
        tick(); expect_out("mid.g2", 4'b0100, 2'd2, 1'b0, 2'd3);
        reset_n = 1'b0;
        tick(); expect_out("mid.reset", 4'b0000, 2'd0, 1'b0, 2'd0);
        reset_n = 1'b1;
        tick(); expect_out("post.reset", 4'b0010, 2'd1, 1'b0, 2'd2);

        // Grantee drops while others still request; later requests wait
        bus.req = 4'b0100;
        tick(); expect_out("drop2", 4'b0000, 2'd0, 1'b0, 2'd2);
        tick(); expect_out("next.g", 4'b0100, 2'd2, 1'b0, 2'd3);
        bus.req = 4'b0101;
        tick(); expect_out("busy.ignore", 4'b0100, 2'd2, 1'b0, 2'd3);
        bus.done = 1'b1;
        tick(); expect_out("done.rel", 4'b0000, 2'd0, 1'b0, 2'd3);
        bus.done = 1'b0;
        tick(); expect_out("wrap", 4'b0001, 2'd0, 1'b0, 2'd1);
        bus.req = 4'b0000;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
